// File: rtl/llc_input_arbiter.sv
// Front-end decoder for the LLC pipeline: picks one channel per decode strobe, ages losers so low
// priority channels cannot starve, runs the reset/flush set walk and flags stalled-request matches.
module llc_input_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int SET_BITS  = 8,
    parameter int TAG_BITS  = 16,
    parameter int AGE_LIMIT = 15,
    parameter int RSP_CH    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            decode_en,
    input  logic [NUM_CH-1:0]               ch_valid,
    input  logic [NUM_CH-1:0]               ch_blocked,
    input  logic [NUM_CH*(TAG_BITS+SET_BITS)-1:0] ch_addr,
    input  logic                            walk_start,
    input  logic                            walk_is_flush,
    input  logic                            stall_valid,
    input  logic [SET_BITS-1:0]             stall_set,
    input  logic [TAG_BITS-1:0]             stall_tag,
    output logic [NUM_CH-1:0]               ch_pop,
    output logic                            grant_valid,
    output logic [NUM_CH-1:0]               grant_ch,
    output logic [SET_BITS-1:0]             grant_set,
    output logic [TAG_BITS-1:0]             grant_tag,
    output logic                            walk_active,
    output logic                            walk_flush,
    output logic                            walk_done,
    output logic                            clr_stall,
    output logic                            look
);

    localparam int LINE_BITS = TAG_BITS + SET_BITS;
    localparam int AGE_W     = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    typedef enum logic {S_IDLE, S_WALK} walk_state_e;

    walk_state_e         state_q, state_d;
    logic [SET_BITS-1:0] walk_set_q, walk_set_d;
    logic                walk_flush_q, walk_flush_d;
    logic                walk_done_q, walk_done_d;

    logic [AGE_W-1:0]    age_q [NUM_CH];
    logic [AGE_W-1:0]    age_d [NUM_CH];

    logic                grant_valid_q;
    logic [NUM_CH-1:0]   grant_ch_q;
    logic [SET_BITS-1:0] grant_set_q;
    logic [TAG_BITS-1:0] grant_tag_q;
    logic                clr_stall_q;

    logic [SET_BITS-1:0] ch_set [NUM_CH];
    logic [TAG_BITS-1:0] ch_tag [NUM_CH];
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   winner;
    logic [SET_BITS-1:0] win_set;
    logic [TAG_BITS-1:0] win_tag;
    logic                found_aged;
    logic                found_any;
    logic                stall_hit;

    assign walk_active = (state_q == S_WALK);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_set[gi]   = ch_addr[gi*LINE_BITS +: SET_BITS];
        assign ch_tag[gi]   = ch_addr[gi*LINE_BITS + SET_BITS +: TAG_BITS];
        assign eligible[gi] = ch_valid[gi] & ~ch_blocked[gi] & ~walk_active;
    end

    // A saturated age beats fixed priority; the walk starves everyone via eligible.
    always_comb begin
        winner     = '0;
        found_aged = 1'b0;
        found_any  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found_aged && eligible[i] && age_q[i] == AGE_MAX) begin
                winner[i]  = 1'b1;
                found_aged = 1'b1;
            end
        end
        if (!found_aged) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found_any && eligible[i]) begin
                    winner[i] = 1'b1;
                    found_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_set = '0;
        win_tag = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner[i]) begin
                win_set = win_set | ch_set[i];
                win_tag = win_tag | ch_tag[i];
            end
        end
    end

    assign stall_hit = winner[RSP_CH] & stall_valid &
                       (win_set == stall_set) & (win_tag == stall_tag);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            age_d[i] = age_q[i];
            if (decode_en) begin
                if (winner[i])
                    age_d[i] = '0;
                else if (eligible[i] && age_q[i] != AGE_MAX)
                    age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        walk_set_d   = walk_set_q;
        walk_flush_d = walk_flush_q;
        walk_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (walk_start) begin
                    state_d      = S_WALK;
                    walk_set_d   = '0;
                    walk_flush_d = walk_is_flush;
                end
            end
            S_WALK: begin
                if (decode_en) begin
                    walk_set_d = walk_set_q + SET_BITS'(1);
                    if (&walk_set_q) begin
                        state_d      = S_IDLE;
                        walk_flush_d = 1'b0;
                        walk_done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            walk_set_q    <= '0;
            walk_flush_q  <= 1'b0;
            walk_done_q   <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
            grant_set_q   <= '0;
            grant_tag_q   <= '0;
            clr_stall_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) age_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            walk_set_q   <= walk_set_d;
            walk_flush_q <= walk_flush_d;
            walk_done_q  <= walk_done_d;
            for (int i = 0; i < NUM_CH; i++) age_q[i] <= age_d[i];
            if (decode_en) begin
                grant_valid_q <= |winner;
                grant_ch_q    <= winner;
                grant_set_q   <= walk_active ? walk_set_q : win_set;
                grant_tag_q   <= win_tag;
                clr_stall_q   <= stall_hit;
            end
        end
    end

    assign ch_pop      = decode_en ? winner : '0;
    assign grant_valid = grant_valid_q;
    assign grant_ch    = grant_ch_q;
    assign grant_set   = grant_set_q;
    assign grant_tag   = grant_tag_q;
    assign walk_flush  = walk_flush_q;
    assign walk_done   = walk_done_q;
    assign clr_stall   = clr_stall_q;
    assign look        = grant_valid_q | (walk_active & walk_flush_q);

endmodule
